// File: rtl/lfsr_pkg.sv
// Shared 16-bit Fibonacci LFSR definitions: width, tap mask, multi-bit step
// function and the server FSM state type.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 16;
  // Taps at bits 15, 13, 12, 10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } rsrv_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                  input int unsigned nbits);
    logic [LFSR_W-1:0] r;
    r = s;
    for (int unsigned i = 0; i < LFSR_W; i++) begin
      if (i < nbits) r = {r[LFSR_W-2:0], ^(r & LFSR_TAPS)};
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p,
                                                input int unsigned off);
    return IDX_W'((32'(p) + off) % NREQ);
  endfunction

  // Scan from the farthest offset down so the nearest request wins last
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (req[wrap_idx(ptr, NREQ - 1 - k)]) begin
        onehot                             = '0;
        onehot[wrap_idx(ptr, NREQ - 1 - k)] = 1'b1;
        idx                                = wrap_idx(ptr, NREQ - 1 - k);
        any                                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfsr_rand_server.sv
// Shared LFSR random source: round-robin grants to NREQ requesters, each grant
// returns OUT_W fresh bits; reseed and reset both run a warm-up before serving.
module lfsr_rand_server
  import lfsr_pkg::*;
#(
  parameter int unsigned       NREQ    = 4,
  parameter int unsigned       OUT_W   = 6,
  parameter logic [LFSR_W-1:0] INITVAL = 16'he45b,
  parameter int unsigned       WARMUP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic              seed_wr,
  input  logic [LFSR_W-1:0] seed_data,
  output logic [NREQ-1:0]   gnt,
  output logic              rnd_vld,
  output logic [OUT_W-1:0]  rnd_out,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = 8;

  rsrv_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              vld_q, vld_d;
  logic [OUT_W-1:0]  rnd_q, rnd_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [LFSR_W-1:0] lfsr_nxt;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign lfsr_nxt = lfsr_step(lfsr_q, OUT_W);

  // Reseed overrides everything; otherwise warm-up steps or serve one grant
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    vld_d   = 1'b0;
    rnd_d   = rnd_q;
    busy_d  = busy_q;
    if (seed_wr) begin
      lfsr_d  = (seed_data == '0) ? INITVAL : seed_data;
      cnt_d   = CNT_W'(WARMUP);
      state_d = WARM;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        WARM: begin
          lfsr_d = lfsr_nxt;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = RUN;
            busy_d  = 1'b0;
          end
        end
        RUN: begin
          if (pick_any) begin
            lfsr_d = lfsr_nxt;
            gnt_d  = pick_oh;
            vld_d  = 1'b1;
            rnd_d  = lfsr_nxt[OUT_W-1:0];
            ptr_d  = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          end
        end
        default: state_d = WARM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WARM;
      cnt_q   <= CNT_W'(WARMUP);
      lfsr_q  <= INITVAL;
      ptr_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      rnd_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign rnd_vld = vld_q;
  assign rnd_out = rnd_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_lfsr_rand_server.sv
// Directed and random checks of lfsr_rand_server against a cycle model.
module tb_lfsr_rand_server;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        seed_wr;
  logic [15:0] seed_data;
  logic [3:0]  gnt;
  logic        rnd_vld;
  logic [5:0]  rnd_out;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  // Cycle model state
  logic [15:0] ms;
  bit          mwarm;
  int          mcnt;
  int          mptr;
  logic [3:0]  eg;
  bit          ev;
  logic [5:0]  er;
  bit          eb;

  logic [5:0]  ref_seq [5];
  logic [3:0]  exp_gnt [5];
  int          waitc [4];
  logic [3:0]  pend;
  logic [15:0] tmp;
  logic [5:0]  held;

  lfsr_rand_server dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .seed_wr   (seed_wr),
    .seed_data (seed_data),
    .gnt       (gnt),
    .rnd_vld   (rnd_vld),
    .rnd_out   (rnd_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_step(input logic [15:0] s, input int n);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int j;
    if (rst) begin
      ms = 16'he45b; mwarm = 1; mcnt = 4; mptr = 0;
      eg = 4'h0; ev = 0; er = 6'h0; eb = 1;
    end else if (seed_wr) begin
      ms = (seed_data == 16'h0) ? 16'he45b : seed_data;
      mwarm = 1; mcnt = 4; eg = 4'h0; ev = 0; eb = 1;
    end else if (mwarm) begin
      ms = m_step(ms, 6);
      mcnt--;
      if (mcnt == 0) mwarm = 0;
      eg = 4'h0; ev = 0; eb = mwarm;
    end else if (req != 4'h0) begin
      j = -1;
      for (int o = 0; o < 4; o++)
        if (j < 0 && req[2'((mptr + o) % 4)]) j = (mptr + o) % 4;
      ms   = m_step(ms, 6);
      eg   = 4'b0001 << j;
      ev   = 1;
      er   = ms[5:0];
      mptr = (j + 1) % 4;
      eb   = 0;
    end else begin
      eg = 4'h0; ev = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("rnd_vld", 32'(rnd_vld), 32'(ev));
    chk("rnd_out", 32'(rnd_out), 32'(er));
    chk("busy", 32'(busy), 32'(eb));
    chk("lfsr_state", 32'(dut.lfsr_q), 32'(ms));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
    chk("lfsr_nonzero", 32'(dut.lfsr_q != 16'h0), 1);
  endtask

  initial begin
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    rst = 1; seed_wr = 0; seed_data = 16'h0; req = 4'h0;
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_vld", 32'(rnd_vld), 0);
    chk("rst_rnd", 32'(rnd_out), 0);
    chk("rst_busy", 32'(busy), 1);

    // 1: warm-up of exactly 4 cycles, then round-robin 0,1,2,3,0
    rst = 0; req = 4'hf;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_busy", 32'(busy), (i < 3) ? 1 : 0);
      chk("t1_nognt", 32'(gnt), 0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_gnt", 32'(gnt), 32'(exp_gnt[i]));
      tmp = m_step(16'he45b, 6 * (5 + i));
      chk("t1_rnd", 32'(rnd_out), 32'(tmp[5:0]));
      ref_seq[i] = er;
    end

    // 2: single pulse on requester 2, LFSR advances once
    req = 4'h0;
    tick();
    chk("t2_idle", 32'(gnt), 0);
    tmp = ms;
    req = 4'b0100;
    tick();
    chk("t2_gnt", 32'(gnt), 32'(4'b0100));
    chk("t2_vld", 32'(rnd_vld), 1);
    chk("t2_adv", 32'(dut.lfsr_q), 32'(m_step(tmp, 6)));
    held = rnd_out;
    req = 4'h0;
    tick();
    chk("t2_drop", 32'(rnd_vld), 0);
    chk("t2_hold", 32'(rnd_out), 32'(held));

    // 3: zero seed with simultaneous request replays the reset sequence
    seed_wr = 1; seed_data = 16'h0; req = 4'hf;
    tick();
    chk("t3_nognt", 32'(gnt), 0);
    chk("t3_busy", 32'(busy), 1);
    seed_wr = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_warm_busy", 32'(busy), (i < 3) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_replay", 32'(rnd_out), 32'(ref_seq[i]));
    end

    // 4: reseed with 1 mid-stream; first grant is step^5 of 16'h0001
    seed_wr = 1; seed_data = 16'h0001;
    tick();
    seed_wr = 0;
    for (int i = 0; i < 4; i++) tick();
    tick();
    chk("t4_rnd", 32'(rnd_out), 32'(6'h14));
    chk("t4_vld", 32'(rnd_vld), 1);

    // 5: reset during RUN with requests pending
    rst = 1;
    tick();
    chk("t5_gnt", 32'(gnt), 0);
    chk("t5_vld", 32'(rnd_vld), 0);
    chk("t5_rnd", 32'(rnd_out), 0);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_ptr", 32'(dut.ptr_q), 0);
    rst = 0;
    for (int i = 0; i < 4; i++) tick();
    tick();
    chk("t5_first_gnt", 32'(gnt), 32'(4'b0001));

    // 6: random held-until-granted requests with occasional reseed
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      seed_wr   = ($urandom_range(0, 499) == 0);
      seed_data = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      pend = req;
      tick();
      if (gnt != 4'h0) begin
        for (int i = 0; i < 4; i++) begin
          if (gnt[i]) begin
            chk("t6_starve", 32'(waitc[i] > 3), 0);
            waitc[i] = 0;
          end else if (pend[i]) begin
            waitc[i]++;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) req[i] = 1'($urandom_range(0, 1));
        else if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
